lsu_mem_responder: RTL and testbench

Data-memory responder answering the load/store requests issued by the pipeline's memory stage. It is the memory side of the interface, replacing the behavioural DPI memory for synthesizable and standalone runs. It is a single-outstanding valid/ready responder over an internal 64-bit-wide memory array. It performs byte-lane placement for stores and extract/extend for loads, and returns a response after a programmable latency.

---
 rtl/lsu_mem_pkg.sv | 32 +++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_mem_responder.sv | 148 ++++++++++++++
 tb/tb_lsu_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the LSU data-memory responder.
// Contents:
//   - SZ_D/SZ_W/SZ_H/SZ_B: one-hot access-size encodings (DWHB).
//   - state_t: responder FSM states.
//   - size_to_mask(): right-aligned byte mask for a one-hot size.
package lsu_mem_pkg;

  localparam logic [3:0] SZ_D = 4'b1000;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_B = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte mask for an access at lane 0; illegal sizes produce no bytes.
  function automatic logic [7:0] size_to_mask(input logic [3:0] size);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      SZ_D:    mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load extract/extend: pulls the addressed bytes out of a 64-bit memory word
// and sign- or zero-extends them to 64 bits.
// Ports:
//   word        in  64  memory word as read from the array
//   lane        in  3   byte offset of the access within the word
//   size        in  4   one-hot DWHB access size
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result      out 64  extended load value (0 for an illegal size)
module lsu_load_align
  import lsu_mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  lane,
  input  logic [3:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Right-align the addressed bytes, then extend from the size's top bit.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    result  = '0;
    case (size)
      SZ_D:    result = shifted;
      SZ_W:    result = {{32{shifted[31] & ~is_unsigned}}, shifted[31:0]};
      SZ_H:    result = {{48{shifted[15] & ~is_unsigned}}, shifted[15:0]};
      SZ_B:    result = {{56{shifted[7]  & ~is_unsigned}}, shifted[7:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Data-memory responder for the pipeline memory stage: single-outstanding
// valid/ready slave over a 64-bit-wide array, with byte-lane store placement,
// load extract/extend and a fixed response latency.
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_ready     request handshake
//   req_we                  1 = store, 0 = load
//   req_addr                byte address
//   req_wdata               right-aligned store data
//   req_size                one-hot DWHB size
//   req_unsigned            load zero-extends when 1
//   resp_valid/resp_ready   response handshake
//   resp_rdata              extended load data; 0 for stores and errors
//   resp_err                misaligned, out-of-range or illegal-size request
module lsu_mem_responder
  import lsu_mem_pkg::*;
#(
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH      = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W      = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned LAT_RELOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [63:0]        mem [DEPTH];

  logic [63:0]           off;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [2:0]            lane;
  logic                  size_ok;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic                  accept;
  logic [7:0]            byte_mask;
  logic [63:0]           bit_mask;
  logic [63:0]           wdata_shift;
  logic [63:0]           load_ext;

  // Address decode, error classification and store lane placement.
  always_comb begin
    off          = req_addr - BASE;
    word_idx     = off[DEPTH_LOG2+2:3];
    lane         = off[2:0];
    size_ok      = (req_size == SZ_D) || (req_size == SZ_W) ||
                   (req_size == SZ_H) || (req_size == SZ_B);
    misaligned   = 1'b0;
    case (req_size)
      SZ_D:    misaligned = (lane != 3'd0);
      SZ_W:    misaligned = (lane[1:0] != 2'd0);
      SZ_H:    misaligned = lane[0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = |off[63:DEPTH_LOG2+3];
    req_err      = !size_ok || misaligned || out_of_range;
    byte_mask    = size_to_mask(req_size) << lane;
    bit_mask     = '0;
    for (int b = 0; b < 8; b++) begin
      bit_mask[8*b +: 8] = {8{byte_mask[b]}};
    end
    wdata_shift  = req_wdata << {lane, 3'b000};
  end

  // Ready while idle, or while the current response is being taken.
  assign req_ready = !reset && ((state == IDLE) || ((state == RESP) && resp_ready));
  assign accept    = req_valid && req_ready;

  lsu_load_align u_load_align (
    .word        (mem[word_idx]),
    .lane        (lane),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .result      (load_ext)
  );

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      mem[word_idx] <= (mem[word_idx] & ~bit_mask) | (wdata_shift & bit_mask);
    end
  end

  // Responder FSM with latency counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase

      // A new accept overrides the transitions above (covers RESP reload).
      if (accept) begin
        resp_rdata <= (req_err || req_we) ? '0 : load_ext;
        resp_err   <= req_err;
        if (LATENCY == 1) begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end else begin
          state      <= WAIT;
          resp_valid <= 1'b0;
          cnt        <= CNT_W'(LAT_RELOAD);
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder: a LATENCY=2 instance driven by a
// directed vector table plus backpressure and reset sequences, and a LATENCY=1
// instance exercised with a back-to-back stream.
module tb_lsu_mem_responder;

  localparam logic [3:0] D = 4'b1000;
  localparam logic [3:0] W = 4'b0100;
  localparam logic [3:0] H = 4'b0010;
  localparam logic [3:0] B = 4'b0001;

  logic clk;
  logic reset;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        req_valid1, req_ready1, req_we1, req_unsigned1;
  logic [63:0] req_addr1, req_wdata1;
  logic [3:0]  req_size1;
  logic        resp_valid1, resp_ready1, resp_err1;
  logic [63:0] resp_rdata1;

  int checks;
  int failures;

  lsu_mem_responder #(.BASE(64'h8000_0000), .DEPTH_LOG2(12), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  lsu_mem_responder #(.BASE(64'h8000_0000), .DEPTH_LOG2(12), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_size(req_size1),
    .req_unsigned(req_unsigned1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
    logic        uns;
    logic [63:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance with resp_ready held high.
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [3:0] size, input logic uns,
                        output logic [63:0] rdata, output logic err, output int lat);
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; seen = 1'b0; rdata = '0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (resp_valid) begin
          seen = 1'b1; lat = k; rdata = resp_rdata; err = resp_err;
        end
      end
    end
    if (seen) @(posedge clk);
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;
  bit          seen;
  logic [63:0] stream_exp [16];

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_size = D; req_unsigned = 0;
    resp_ready = 1'b1;
    req_valid1 = 0; req_we1 = 0; req_addr1 = '0; req_wdata1 = '0; req_size1 = D; req_unsigned1 = 0;
    resp_ready1 = 1'b1;

    vecs[0]  = '{1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, D, 1'b0, 64'h0, 1'b0, "st_d0"};
    vecs[1]  = '{1'b0, 64'h8000_0000, 64'h0, D, 1'b0, 64'h1122_3344_5566_7788, 1'b0, "ld_d0"};
    vecs[2]  = '{1'b1, 64'h8000_0003, 64'hFFFF_FFFF_FFFF_FFF0, B, 1'b0, 64'h0, 1'b0, "st_b3"};
    vecs[3]  = '{1'b0, 64'h8000_0003, 64'h0, B, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, "ld_b3"};
    vecs[4]  = '{1'b0, 64'h8000_0003, 64'h0, B, 1'b1, 64'h0000_0000_0000_00F0, 1'b0, "ld_bu3"};
    vecs[5]  = '{1'b0, 64'h8000_0000, 64'h0, D, 1'b0, 64'h1122_3344_F066_7788, 1'b0, "ld_d0_merged"};
    vecs[6]  = '{1'b0, 64'h8000_0002, 64'h0, W, 1'b0, 64'h0, 1'b1, "ld_w_misaligned"};
    vecs[7]  = '{1'b1, 64'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, D, 1'b0, 64'h0, 1'b1, "st_out_of_range"};
    vecs[8]  = '{1'b0, 64'h8000_0000, 64'h0, D, 1'b0, 64'h1122_3344_F066_7788, 1'b0, "ld_d0_after_oor"};
    vecs[9]  = '{1'b0, 64'h8000_0000, 64'h0, 4'b0110, 1'b0, 64'h0, 1'b1, "ld_bad_size"};
    vecs[10] = '{1'b1, 64'h8000_0008, 64'h0102_0304_0506_0708, D, 1'b0, 64'h0, 1'b0, "st_d8"};
    vecs[11] = '{1'b1, 64'h8000_000A, 64'hFFFF_FFFF_FFFF_ABCD, H, 1'b0, 64'h0, 1'b0, "st_ha"};
    vecs[12] = '{1'b0, 64'h8000_000A, 64'h0, H, 1'b0, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0, "ld_ha"};
    vecs[13] = '{1'b0, 64'h8000_000A, 64'h0, H, 1'b1, 64'h0000_0000_0000_ABCD, 1'b0, "ld_hua"};
    vecs[14] = '{1'b0, 64'h8000_0008, 64'h0, D, 1'b0, 64'h0102_0304_ABCD_0708, 1'b0, "ld_d8"};
    vecs[15] = '{1'b1, 64'h8000_000C, 64'h1234_5678_8765_4321, W, 1'b0, 64'h0, 1'b0, "st_wc"};
    vecs[16] = '{1'b0, 64'h8000_000C, 64'h0, W, 1'b0, 64'hFFFF_FFFF_8765_4321, 1'b0, "ld_wc"};
    vecs[17] = '{1'b0, 64'h8000_000C, 64'h0, W, 1'b1, 64'h0000_0000_8765_4321, 1'b0, "ld_wuc"};
    vecs[18] = '{1'b0, 64'h8000_0008, 64'h0, D, 1'b0, 64'h8765_4321_ABCD_0708, 1'b0, "ld_d8_merged"};
    vecs[19] = '{1'b0, 64'h8000_0001, 64'h0, H, 1'b0, 64'h0, 1'b1, "ld_h_misaligned"};
    vecs[20] = '{1'b0, 64'h8000_0004, 64'h0, D, 1'b0, 64'h0, 1'b1, "ld_d_misaligned"};
    vecs[21] = '{1'b0, 64'h7FFF_FFF8, 64'h0, D, 1'b0, 64'h0, 1'b1, "ld_below_base"};
    vecs[22] = '{1'b1, 64'h8000_7FFF, 64'h0000_0000_0000_005A, B, 1'b0, 64'h0, 1'b0, "st_b_top"};
    vecs[23] = '{1'b0, 64'h8000_7FFF, 64'h0, B, 1'b1, 64'h0000_0000_0000_005A, 1'b0, "ld_bu_top"};
    vecs[24] = '{1'b1, 64'h8000_0006, 64'hFFFF_FFFF_FFFF_FFFF, W, 1'b0, 64'h0, 1'b1, "st_w_misaligned"};
    vecs[25] = '{1'b0, 64'h8000_0000, 64'h0, D, 1'b0, 64'h1122_3344_F066_7788, 1'b0, "ld_d0_final"};

    // Reset state on both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",   64'(req_ready),   64'd0);
    chk("rst_resp_valid",  64'(resp_valid),  64'd0);
    chk("rst_resp_rdata",  resp_rdata,       64'd0);
    chk("rst_resp_err",    64'(resp_err),    64'd0);
    chk("rst_req_ready1",  64'(req_ready1),  64'd0);
    chk("rst_resp_valid1", 64'(resp_valid1), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Directed vector table.
    for (int i = 0; i < 26; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, lat);
      chk({vecs[i].name, "_rdata"},   rd,         vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"},     64'(er),    64'(vecs[i].exp_err));
      chk({vecs[i].name, "_latency"}, 64'(lat),   64'd2);
    end

    // Backpressure: response held for 5 cycles, then released with a new request pending.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0000; req_size = D; req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_addr = 64'h8000_0003; req_size = B; req_unsigned = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (resp_valid) seen = 1'b1;
      end
    end
    chk("bp_resp_seen", 64'(seen), 64'd1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 64'(resp_valid), 64'd1);
      chk("bp_hold_rdata", resp_rdata, 64'h1122_3344_F066_7788);
      chk("bp_hold_err",   64'(resp_err), 64'd0);
      chk("bp_req_ready",  64'(req_ready), 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_wait", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("bp_next_valid", 64'(resp_valid), 64'd1);
    chk("bp_next_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_back_idle", 64'(resp_valid), 64'd0);

    // LATENCY=1 instance: 8 stores then 8 loads (reverse order), back to back.
    for (int i = 0; i < 16; i++) begin
      stream_exp[i] = (i < 8) ? 64'h0 : (64'h0123_4567_0000_0000 + 64'(15 - i));
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("s1_resp_valid", 64'(resp_valid1), 64'd1);
        chk("s1_resp_rdata", resp_rdata1, stream_exp[i-1]);
        chk("s1_resp_err",   64'(resp_err1), 64'd0);
      end
      if (i < 16) begin
        chk("s1_req_ready", 64'(req_ready1), 64'd1);
        req_valid1 = 1'b1; req_size1 = D; req_unsigned1 = 1'b0;
        if (i < 8) begin
          req_we1 = 1'b1; req_addr1 = 64'h8000_0100 + 64'(8 * i);
          req_wdata1 = 64'h0123_4567_0000_0000 + 64'(i);
        end else begin
          req_we1 = 1'b0; req_addr1 = 64'h8000_0100 + 64'(8 * (15 - i));
          req_wdata1 = '0;
        end
      end else begin
        req_valid1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("s1_drained", 64'(resp_valid1), 64'd0);

    // Reset while waiting on an accepted store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h8000_0010;
    req_wdata = 64'hCAFE_F00D_1234_5678; req_size = D; req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rw_resp_valid", 64'(resp_valid), 64'd0);
    chk("rw_req_ready",  64'(req_ready),  64'd0);
    @(negedge clk);
    chk("rw_resp_valid2", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_idle_ready", 64'(req_ready),  64'd1);
    chk("rw_idle_valid", 64'(resp_valid), 64'd0);
    do_req(1'b0, 64'h8000_0010, 64'h0, D, 1'b0, rd, er, lat);
    chk("rw_load_rdata",   rd,       64'hCAFE_F00D_1234_5678);
    chk("rw_load_err",     64'(er),  64'd0);
    chk("rw_load_latency", 64'(lat), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
